// File: rtl/ps2_key_emitter.sv
// Keyboard-side PS/2 transmitter: each accepted ASCII character becomes a full
// keystroke (make, F0, make; Shift-wrapped for capitals) sent as 11-bit frames.
module ps2_key_emitter #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP        = 8,
  parameter logic [7:0]  SHIFT_CODE = 8'h12,
  parameter logic [7:0]  BREAK_CODE = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       valid,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       err,
  output logic [7:0] sent_count
);

  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(10);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_BIT, S_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_ascii, w_ascii_nxt;
  logic [7:0]         r_code, w_code_nxt;
  logic               r_shift, w_shift_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               r_clk, w_clk_nxt;
  logic               r_data, w_data_nxt;
  logic               r_ready, w_ready_nxt;
  logic               r_err, w_err_nxt;
  logic [7:0]         r_count, w_count_nxt;

  logic               w_lk_ok, w_lk_shift;
  logic [7:0]         w_lk_code;
  logic [7:0]         w_byte;
  logic [10:0]        w_frame;
  logic [IDX_W-1:0]   w_last_idx;
  logic [BIT_W-1:0]   w_bit_inc;

  function automatic logic [7:0] letter_code(input logic [4:0] n);
    case (n)
      5'd0:  return 8'h1C;  5'd1:  return 8'h32;  5'd2:  return 8'h21;
      5'd3:  return 8'h23;  5'd4:  return 8'h24;  5'd5:  return 8'h2B;
      5'd6:  return 8'h34;  5'd7:  return 8'h33;  5'd8:  return 8'h43;
      5'd9:  return 8'h3B;  5'd10: return 8'h42;  5'd11: return 8'h4B;
      5'd12: return 8'h3A;  5'd13: return 8'h31;  5'd14: return 8'h44;
      5'd15: return 8'h4D;  5'd16: return 8'h15;  5'd17: return 8'h2D;
      5'd18: return 8'h1B;  5'd19: return 8'h2C;  5'd20: return 8'h3C;
      5'd21: return 8'h2A;  5'd22: return 8'h1D;  5'd23: return 8'h22;
      5'd24: return 8'h35;  5'd25: return 8'h1A;
      default: return 8'h00;
    endcase
  endfunction

  // Returns {supported, need_shift, scan_code}
  function automatic logic [9:0] lookup(input logic [7:0] a);
    logic       ok;
    logic       sh;
    logic [7:0] code;
    ok   = 1'b1;
    sh   = 1'b0;
    code = 8'h00;
    if (a >= 8'h61 && a <= 8'h7A) begin
      code = letter_code(5'(a - 8'h61));
    end else if (a >= 8'h41 && a <= 8'h5A) begin
      code = letter_code(5'(a - 8'h41));
      sh   = 1'b1;
    end else begin
      case (a)
        8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1E;
        8'h33: code = 8'h26;  8'h34: code = 8'h25;  8'h35: code = 8'h2E;
        8'h36: code = 8'h36;  8'h37: code = 8'h3D;  8'h38: code = 8'h3E;
        8'h39: code = 8'h46;  8'h20: code = 8'h29;  8'h0D: code = 8'h5A;
        default: ok = 1'b0;
      endcase
    end
    return {ok, sh, code};
  endfunction

  assign {w_lk_ok, w_lk_shift, w_lk_code} = lookup(r_ascii);

  // Byte currently being framed, selected by position in the keystroke
  always_comb begin
    w_byte = r_code;
    if (r_shift) begin
      case (r_idx)
        3'd0, 3'd5: w_byte = SHIFT_CODE;
        3'd2, 3'd4: w_byte = BREAK_CODE;
        default:    w_byte = r_code;
      endcase
    end else if (r_idx == 3'd1) begin
      w_byte = BREAK_CODE;
    end
  end

  assign w_frame    = {1'b1, ~^w_byte, w_byte, 1'b0};
  assign w_last_idx = r_shift ? 3'd5 : 3'd2;
  assign w_bit_inc  = r_bit + BIT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ascii_nxt = r_ascii;
    w_code_nxt  = r_code;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_bit_nxt   = r_bit;
    w_div_nxt   = r_div;
    w_gap_nxt   = r_gap;
    w_clk_nxt   = r_clk;
    w_data_nxt  = r_data;
    w_err_nxt   = 1'b0;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (valid) begin
          w_ascii_nxt = ascii_in;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_lk_ok) begin
          w_code_nxt  = w_lk_code;
          w_shift_nxt = w_lk_shift;
          w_idx_nxt   = '0;
          w_bit_nxt   = '0;
          w_div_nxt   = '0;
          w_clk_nxt   = 1'b1;
          w_data_nxt  = 1'b0;
          w_state_nxt = S_START;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      // START carries the start bit, BIT carries d0..stop; data moves only at bit start
      S_START, S_BIT: begin
        w_div_nxt = r_div + DIV_W'(1);
        if (r_div == DIV_W'(CLK_DIV - 1)) begin
          w_clk_nxt = 1'b0;
        end else if (r_div == DIV_W'(2 * CLK_DIV - 1)) begin
          w_div_nxt = '0;
          w_clk_nxt = 1'b1;
          if (r_bit == LAST_BIT) begin
            w_bit_nxt  = '0;
            w_data_nxt = 1'b1;
            if (r_idx == w_last_idx) begin
              w_count_nxt = r_count + 8'd1;
              w_state_nxt = S_IDLE;
            end else begin
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_gap_nxt   = '0;
              w_state_nxt = S_GAP;
            end
          end else begin
            w_bit_nxt   = w_bit_inc;
            w_data_nxt  = w_frame[w_bit_inc];
            w_state_nxt = S_BIT;
          end
        end
      end
      S_GAP: begin
        w_gap_nxt = r_gap + GAP_W'(1);
        if (r_gap == GAP_W'(GAP - 1)) begin
          w_bit_nxt   = '0;
          w_div_nxt   = '0;
          w_clk_nxt   = 1'b1;
          w_data_nxt  = 1'b0;
          w_state_nxt = S_START;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ascii <= '0;
      r_code  <= '0;
      r_shift <= 1'b0;
      r_idx   <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_gap   <= '0;
      r_clk   <= 1'b1;
      r_data  <= 1'b1;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ascii <= w_ascii_nxt;
      r_code  <= w_code_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_bit   <= w_bit_nxt;
      r_div   <= w_div_nxt;
      r_gap   <= w_gap_nxt;
      r_clk   <= w_clk_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign ready      = r_ready;
  assign ps2_clk    = r_clk;
  assign ps2_data   = r_data;
  assign err        = r_err;
  assign sent_count = r_count;

endmodule

// File: tb/tb_ps2_key_emitter.sv
// Bench for ps2_key_emitter: a timeline model of the expected line waveform,
// a frame decoder on the lines, and directed plus random keystrokes.
module tb_ps2_key_emitter;

  localparam int CD = 4;
  localparam int GP = 8;
  localparam int F  = 22 * CD;
  localparam int P  = F + GP;
  localparam logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ascii_in;
  logic       valid;
  logic       ready, ps2_clk, ps2_data, err;
  logic [7:0] sent_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int err_seen = 0;

  ps2_key_emitter #(.CLK_DIV(CD), .GAP(GP)) dut (
    .clk(clk), .reset(reset), .ascii_in(ascii_in), .valid(valid), .ready(ready),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .err(err), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference rules: character -> scan code, keystroke byte list, frame bits
  function automatic void tb_lookup(input logic [7:0] c, output bit ok, output bit sh,
                                    output logic [7:0] code);
    ok = 1; sh = 0; code = 8'h00;
    if (c >= 8'h61 && c <= 8'h7A) code = LET[int'(c) - 'h61];
    else if (c >= 8'h41 && c <= 8'h5A) begin code = LET[int'(c) - 'h41]; sh = 1; end
    else if (c >= 8'h30 && c <= 8'h39) code = DIG[int'(c) - 'h30];
    else if (c == 8'h20) code = 8'h29;
    else if (c == 8'h0D) code = 8'h5A;
    else ok = 0;
  endfunction

  function automatic bit fbit(input logic [7:0] b8, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b8[i-1];
    if (i == 9) return ~^b8;
    return 1'b1;
  endfunction

  bit         m_busy = 0, m_ok = 0, m_err_now = 0;
  int         m_n = 0, m_len = 0;
  logic [7:0] m_count = 0, m_char = 0;
  logic [7:0] m_bytes[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_n = 0; m_count = 0; m_err_now = 0;
    end else begin
      m_err_now = 0;
      if (m_busy) begin
        m_n++;
        if (m_n == m_len) begin
          m_busy = 0;
          if (m_ok) m_count++;
          else m_err_now = 1;
        end
      end else if (valid) begin
        bit sh;
        logic [7:0] code;
        m_char = ascii_in;
        tb_lookup(ascii_in, m_ok, sh, code);
        m_bytes.delete();
        if (m_ok) begin
          if (sh) m_bytes = '{8'h12, code, 8'hF0, code, 8'hF0, 8'h12};
          else    m_bytes = '{code, 8'hF0, code};
          m_len = 1 + m_bytes.size() * F + (m_bytes.size() - 1) * GP;
        end else begin
          m_len = 1;
        end
        m_busy = 1; m_n = 0;
      end
    end
  end

  bit         prev_clk = 1;
  int         dec_n = 0;
  logic [10:0] dec_sh;
  logic [7:0] dec_q[$];
  bit         par_q[$];
  int         falls[$];

  // Per-cycle comparison against the model, plus frame decoding of the lines
  always @(negedge clk) begin
    bit e_clk, e_data;
    int o, k, r;
    cyc++;
    if (!reset) begin
      e_clk = 1; e_data = 1;
      if (m_busy && m_n > 0) begin
        o = m_n - 1; k = o / P; r = o % P;
        if (r < F) begin
          e_clk  = ((r % (2 * CD)) < CD);
          e_data = fbit(m_bytes[k], r / (2 * CD));
        end
      end
      chk("ps2_clk", 32'(ps2_clk), 32'(e_clk));
      chk("ps2_data", 32'(ps2_data), 32'(e_data));
      chk("ready", 32'(ready), 32'(!m_busy));
      chk("err", 32'(err), 32'(m_err_now));
      chk("sent_count", 32'(sent_count), 32'(m_count));
      if (err) err_seen++;
      if (prev_clk && !ps2_clk) begin
        falls.push_back(cyc);
        dec_sh[dec_n] = ps2_data;
        dec_n++;
        if (dec_n == 11) begin
          chk("frame_start", 32'(dec_sh[0]), 32'd0);
          chk("frame_stop", 32'(dec_sh[10]), 32'd1);
          dec_q.push_back(dec_sh[8:1]);
          par_q.push_back(dec_sh[9]);
          dec_n = 0;
        end
      end
      prev_clk = ps2_clk;
    end else begin
      dec_n = 0;
      prev_clk = 1;
    end
  end

  task automatic clear_mon();
    dec_q.delete(); par_q.delete(); falls.delete();
  endtask

  task automatic send(input logic [7:0] c);
    @(posedge clk); #2;
    ascii_in = c; valid = 1'b1;
    @(posedge clk); #2;
    valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #2;
      done = !m_busy;
    end
    chk({name, "_idle_timeout"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_bytes(input string name, input logic [7:0] ex[$]);
    chk({name, "_nbytes"}, 32'(dec_q.size()), 32'(ex.size()));
    for (int i = 0; i < ex.size() && i < dec_q.size(); i++)
      chk({name, "_byte"}, 32'(dec_q[i]), 32'(ex[i]));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [3:0] ev;
    int e0, lows;
    bit done;
    reset = 1'b1; valid = 1'b0; ascii_in = 8'h00;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    chk("rst_ps2_data", 32'(ps2_data), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(sent_count), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Lowercase 'a'
    clear_mon();
    send(8'h61);
    wait_idle("a");
    q = '{8'h1C, 8'hF0, 8'h1C};
    chk_bytes("a", q);
    chk("a_parity", par_q.size() == 3 ? 32'({par_q[0], par_q[1], par_q[2]}) : 32'hFFFF, 32'b010);
    chk("a_first_fall", falls.size() > 0 ? 32'(falls[0] - acc_cyc) : 32'hFFFF, 32'd6);
    chk("a_frame_period", falls.size() > 11 ? 32'(falls[11] - falls[0]) : 32'hFFFF, 32'd96);
    chk("a_count", 32'(sent_count), 32'd1);
    chk("a_ready", 32'(ready), 32'd1);

    // Uppercase 'A'
    clear_mon();
    e0 = err_seen;
    send(8'h41);
    wait_idle("A");
    q = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    chk_bytes("A", q);
    chk("A_no_err", 32'(err_seen - e0), 32'd0);
    chk("A_count", 32'(sent_count), 32'd2);

    // Unsupported 0x7F
    clear_mon();
    send(8'h7F);
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ev[3-i] = err;
      if (i == 1) chk("7F_ready", 32'(ready), 32'd1);
      if (!ps2_clk) lows++;
    end
    repeat (10) begin @(negedge clk); if (!ps2_clk) lows++; end
    chk("7F_err_pulse", 32'(ev), 32'b0100);
    chk("7F_no_clk", 32'(lows), 32'd0);
    chk("7F_count", 32'(sent_count), 32'd2);

    // Back-to-back with valid held, then an ignored request while busy
    clear_mon();
    @(posedge clk); #2;
    ascii_in = 8'h31; valid = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin @(posedge clk); #2; done = m_busy; end
    chk("bb_acc1", 32'(done), 32'd1);
    ascii_in = 8'h20;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #2; done = m_busy && (m_char == 8'h20);
    end
    chk("bb_acc2", 32'(done), 32'd1);
    valid = 1'b0;
    repeat (50) @(posedge clk);
    #2 ascii_in = 8'h35; valid = 1'b1;
    @(posedge clk); #2 valid = 1'b0;
    wait_idle("bb");
    q = '{8'h16, 8'hF0, 8'h16, 8'h29, 8'hF0, 8'h29};
    chk_bytes("bb", q);
    repeat (20) @(negedge clk);
    chk("bb_count", 32'(sent_count), 32'd4);

    // Reset during d3 of the second frame of 'A'
    clear_mon();
    send(8'h41);
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin @(posedge clk); #2; done = (m_n >= 134); end
    chk("mid_reached", 32'(done), 32'd1);
    chk("mid_pre_clk", 32'(ps2_clk), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_ps2_clk", 32'(ps2_clk), 32'd1);
    chk("mid_ps2_data", 32'(ps2_data), 32'd1);
    chk("mid_ready", 32'(ready), 32'd1);
    chk("mid_count", 32'(sent_count), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    clear_mon();
    send(8'h7A);
    wait_idle("z");
    q = '{8'h1A, 8'hF0, 8'h1A};
    chk_bytes("z", q);
    chk("z_count", 32'(sent_count), 32'd1);

    // A few random characters (mix of supported and unsupported)
    for (int n = 0; n < 6; n++) begin
      logic [7:0] c;
      bit ok, sh;
      logic [7:0] code;
      c = 8'($urandom_range(0, 127));
      tb_lookup(c, ok, sh, code);
      clear_mon();
      send(c);
      wait_idle("rnd");
      chk("rnd_nbytes", 32'(dec_q.size()), ok ? (sh ? 32'd6 : 32'd3) : 32'd0);
    end

    // Counter wrap from zero
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    for (int n = 0; n < 255; n++) begin
      clear_mon();
      send(8'h30);
      wait_idle("wrap");
    end
    chk("wrap_ff", 32'(sent_count), 32'hFF);
    send(8'h30);
    wait_idle("wrap_last");
    chk("wrap_00", 32'(sent_count), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
